// File: rtl/inject_arbiter.sv
// inject_arbiter: two per-requester flit FIFOs feeding a router inject port.
// Round-robin selection between the FIFOs, gated by a credit counter that
// tracks free slots in the router local-input buffer.
module inject_arbiter #(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [19:0] req0_data,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [19:0] req1_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        ci,
  output logic [19:0] dataout,
  output logic        out_valid,
  output logic        out_src,
  output logic [2:0]  credit_cnt,
  output logic        credit_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [2:0]    CRED_MAX = 3'(CREDITS);

  // FIFO storage and bookkeeping, indexed by requester
  logic [19:0]   mem_q  [2][DEPTH];
  logic [19:0]   mem_d  [2][DEPTH];
  logic [AW-1:0] wptr_q [2];
  logic [AW-1:0] wptr_d [2];
  logic [AW-1:0] rptr_q [2];
  logic [AW-1:0] rptr_d [2];
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];

  // Arbiter / output / credit state
  logic        prio_q, prio_d;
  logic [19:0] dout_q, dout_d;
  logic        oval_q, oval_d;
  logic        src_q, src_d;
  logic [2:0]  credit_q, credit_d;
  logic        err_q, err_d;

  logic [19:0] in_data_s [2];
  logic [1:0]  in_valid_s;
  logic [1:0]  push_s;
  logic [1:0]  pop_s;
  logic [1:0]  nonempty_s;
  logic        send_s;
  logic        win_s;
  logic [19:0] head_s;

  assign in_data_s[0] = req0_data;
  assign in_data_s[1] = req1_data;
  assign in_valid_s   = {req1_valid, req0_valid};

  // Readiness depends only on stored occupancy; forced low while reset is held
  assign req0_ready = !RST && (cnt_q[0] != FULL_CNT);
  assign req1_ready = !RST && (cnt_q[1] != FULL_CNT);

  // Send eligibility, round-robin winner selection and push/pop strobes
  always_comb begin
    nonempty_s[0] = (cnt_q[0] != '0);
    nonempty_s[1] = (cnt_q[1] != '0);
    send_s = (credit_q != 3'd0) && (nonempty_s != 2'b00);
    if (nonempty_s[prio_q]) begin
      win_s = prio_q;
    end else begin
      win_s = ~prio_q;
    end
    head_s = mem_q[win_s][rptr_q[win_s]];
    pop_s  = 2'b00;
    if (send_s) begin
      pop_s[win_s] = 1'b1;
    end else begin
      pop_s = 2'b00;
    end
    push_s[0] = in_valid_s[0] && (cnt_q[0] != FULL_CNT);
    push_s[1] = in_valid_s[1] && (cnt_q[1] != FULL_CNT);
  end

  // FIFO next-state: write at tail, advance pointers, track occupancy
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < 2; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      if (push_s[i]) begin
        mem_d[i][wptr_q[i]] = in_data_s[i];
        wptr_d[i] = wptr_q[i] + AW'(1);
      end else begin
        wptr_d[i] = wptr_q[i];
      end
      if (pop_s[i]) begin
        rptr_d[i] = rptr_q[i] + AW'(1);
      end else begin
        rptr_d[i] = rptr_q[i];
      end
      cnt_d[i] = cnt_q[i] + CW'(push_s[i]) - CW'(pop_s[i]);
    end
  end

  // Output register, priority pointer and credit accounting next-state
  always_comb begin
    oval_d   = send_s;
    dout_d   = dout_q;
    src_d    = src_q;
    prio_d   = prio_q;
    credit_d = credit_q;
    err_d    = err_q;
    if (send_s) begin
      dout_d = head_s;
      src_d  = win_s;
      prio_d = ~win_s;
    end else begin
      dout_d = dout_q;
      src_d  = src_q;
      prio_d = prio_q;
    end
    case ({send_s, ci})
      2'b10: credit_d = credit_q - 3'd1;
      2'b01: begin
        if (credit_q == CRED_MAX) begin
          err_d = 1'b1;
        end else begin
          credit_d = credit_q + 3'd1;
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  // FIFO payload storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      prio_q   <= 1'b0;
      dout_q   <= 20'h00000;
      oval_q   <= 1'b0;
      src_q    <= 1'b0;
      credit_q <= CRED_MAX;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      prio_q   <= prio_d;
      dout_q   <= dout_d;
      oval_q   <= oval_d;
      src_q    <= src_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign dataout    = dout_q;
  assign out_valid  = oval_q;
  assign out_src    = src_q;
  assign credit_cnt = credit_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_inject_arbiter.sv
// Randomized self-checking bench for inject_arbiter with a queue-based model.
module tb_inject_arbiter;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] d0, d1;
  logic        v0, v1, ci;
  logic        r0, r1;
  logic [19:0] dout;
  logic        ov, src, cerr;
  logic [2:0]  cc;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [19:0] q0[$];
  logic [19:0] q1[$];
  int          m_cred = CREDITS;
  bit          m_prio = 1'b0;
  bit          m_oval = 1'b0;
  bit          m_src  = 1'b0;
  bit          m_err  = 1'b0;
  logic [19:0] m_dout = 20'h00000;

  int          seq = 1;
  bit          srcs[$];

  always #5 clk = ~clk;

  inject_arbiter #(.DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
    .clk(clk), .RST(rst),
    .req0_data(d0), .req0_valid(v0), .req0_ready(r0),
    .req1_data(d1), .req1_valid(v1), .req1_ready(r1),
    .ci(ci), .dataout(dout), .out_valid(ov), .out_src(src),
    .credit_cnt(cc), .credit_err(cerr)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one rising edge to the model using the currently driven inputs
  task automatic model_edge();
    int s0, s1;
    bit snd, win;
    if (rst) begin
      q0.delete(); q1.delete();
      m_prio = 1'b0; m_cred = CREDITS; m_dout = 20'h00000;
      m_oval = 1'b0; m_src = 1'b0; m_err = 1'b0;
    end else begin
      s0 = q0.size(); s1 = q1.size();
      snd = (m_cred > 0) && (s0 > 0 || s1 > 0);
      win = m_prio;
      if (snd) begin
        if (win == 1'b0 && s0 == 0) win = 1'b1;
        else if (win == 1'b1 && s1 == 0) win = 1'b0;
        if (win == 1'b0) m_dout = q0.pop_front();
        else m_dout = q1.pop_front();
        m_src = win;
        m_prio = !win;
      end
      m_oval = snd;
      if (v0 && s0 < DEPTH) q0.push_back(d0);
      if (v1 && s1 < DEPTH) q1.push_back(d1);
      if (ci && !snd && m_cred == CREDITS) m_err = 1'b1;
      else m_cred = m_cred - int'(snd) + int'(ci);
    end
  endtask

  task automatic check_all();
    check_val("out_valid", ov, m_oval);
    check_val("dataout", dout, m_dout);
    check_val("out_src", src, m_src);
    check_val("credit_cnt", cc, m_cred);
    check_val("credit_err", cerr, m_err);
    check_val("req0_ready", r0, (!rst && q0.size() < DEPTH));
    check_val("req1_ready", r1, (!rst && q1.size() < DEPTH));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (ov) srcs.push_back(src);
    check_all();
  endtask

  task automatic idle_inputs();
    v0 = 1'b0; v1 = 1'b0; ci = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle_inputs(); d0 = 20'h00000; d1 = 20'h00000;
    #1;
    step(); step();
    check_val("reset_ready0", r0, 1'b0);
    check_val("reset_credit", cc, 3'd4);

    // Single flit latency
    rst = 1'b0; #1;
    check_val("ready_after_rst", r0, 1'b1);
    v0 = 1'b1; d0 = 20'h0ABCD;
    step();
    v0 = 1'b0;
    step();
    check_val("single_valid", ov, 1'b1);
    check_val("single_dout", dout, 20'h0ABCD);
    check_val("single_src", src, 1'b0);
    check_val("single_credit", cc, 3'd3);
    step();
    check_val("single_valid_drop", ov, 1'b0);

    // Round-robin drain of all credits
    rst = 1'b1; step(); rst = 1'b0;
    srcs.delete();
    for (int i = 0; i < 10; i++) begin
      v0 = (i < 3); v1 = (i < 3);
      d0 = 20'(seq); d1 = 20'(seq + 1); seq += 2;
      step();
    end
    idle_inputs();
    check_val("rr_count", srcs.size(), 4);
    for (int i = 0; i < 4 && i < srcs.size(); i++)
      check_val("rr_src", srcs[i], i % 2);
    check_val("rr_credit_zero", cc, 3'd0);
    check_val("rr_stalled", ov, 1'b0);

    // Credit stall and resume
    ci = 1'b1; step(); ci = 1'b0;
    check_val("resume_credit", cc, 3'd1);
    check_val("resume_nosend", ov, 1'b0);
    step();
    check_val("resume_send", ov, 1'b1);
    check_val("resume_credit0", cc, 3'd0);

    // Backpressure on req0 with no credits
    for (int i = 0; i < 5; i++) begin
      v0 = 1'b1; d0 = 20'(seq); seq++;
      step();
      check_val("bp_ready", r0, (i < 3) ? 1'b1 : 1'b0);
    end
    v0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ci = (i % 2 == 0); step();
    end
    idle_inputs();

    // Overflow and simultaneous send+ci
    rst = 1'b1; step(); rst = 1'b0;
    ci = 1'b1; step(); ci = 1'b0;
    check_val("ovf_err", cerr, 1'b1);
    check_val("ovf_credit", cc, 3'd4);
    v0 = 1'b1; d0 = 20'(seq); seq++; step(); v0 = 1'b0;
    ci = 1'b1; step(); ci = 1'b0;
    check_val("sim_send", ov, 1'b1);
    check_val("sim_credit", cc, 3'd4);

    // Mid-operation reset with loaded FIFOs
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      v0 = (i < 3); v1 = (i < 3); d0 = 20'(seq); d1 = 20'(seq + 1); seq += 2;
      step();
    end
    idle_inputs();
    rst = 1'b1; step(); step();
    check_val("mid_rst_ready0", r0, 1'b0);
    check_val("mid_rst_ready1", r1, 1'b0);
    check_val("mid_rst_valid", ov, 1'b0);
    check_val("mid_rst_credit", cc, 3'd4);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_val("mid_rst_no_stale", ov, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      v0 = ($urandom_range(0, 99) < 55);
      v1 = ($urandom_range(0, 99) < 55);
      d0 = 20'($urandom); d1 = 20'($urandom);
      ci = ($urandom_range(0, 99) < 40);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    idle_inputs(); rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
